// File: rtl/anc_pkg.sv
// Shared definitions for the LMS core: FSM state encoding and the headroom used
// by the round/saturate stage.
package anc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One guard bit so that adding the rounding bias can never wrap the product.
  localparam int SR_GUARD = 1;

endpackage

// File: rtl/anc_sat_round.sv
// Combinational round-half-up by FRAC bits followed by saturation to OW bits;
// ovf flags any clipping.
module anc_sat_round
  import anc_pkg::*;
#(
  parameter int IW   = 33,
  parameter int OW   = 16,
  parameter int FRAC = 15
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 ovf
);

  localparam int EW  = IW + SR_GUARD;
  localparam int BSH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [EW-1:0] BIAS = (FRAC > 0) ? (EW'(1) <<< BSH) : '0;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  logic signed [EW-1:0] biased;
  logic signed [EW-1:0] shifted;

  always_comb begin
    biased  = EW'(din) + BIAS;
    shifted = biased >>> FRAC;
    ovf     = 1'b0;
    dout    = shifted[OW-1:0];
    if (shifted > MAXV) begin
      dout = MAXV[OW-1:0];
      ovf  = 1'b1;
    end else if (shifted < MINV) begin
      dout = MINV[OW-1:0];
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/lms_core_mc.sv
// Multi-channel LMS weight-update core: scales (error - desired) by u_in, launches an
// external FIR and holds its result until out_ready; FIR stalls are bounded by TMO.
module lms_core_mc
  import anc_pkg::*;
#(
  parameter  int DW   = 16,
  parameter  int AW   = 32,
  parameter  int FRAC = 15,
  parameter  int NCH  = 4,
  parameter  int TMO  = 255,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CW   = (TMO > 0) ? $clog2(TMO + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [DW-1:0] error_in,
  input  logic signed [DW-1:0] desired_in,
  input  logic signed [DW-1:0] feedforward_in,
  input  logic signed [DW-1:0] u_in,
  output logic                 fir_go,
  output logic [CHW-1:0]       fir_ch,
  output logic signed [AW-1:0] feedforward_out,
  input  logic                 fir_done,
  input  logic signed [AW-1:0] fir_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic signed [AW-1:0] out_sample,
  output logic signed [DW-1:0] weight_adjust,
  output logic [NCH-1:0]       sat_flags,
  input  logic [NCH-1:0]       sat_clr,
  output logic                 timeout
);

  localparam int PW = 2 * DW + 1;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic accept, take, tmo_hit;

  logic signed [DW:0]   diff;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] wa_nxt;
  logic                 wa_ovf;
  logic [NCH-1:0]       set_vec;

  // Full-width difference and product so only the final rounding drops precision.
  always_comb begin
    diff = (DW+1)'(error_in) - (DW+1)'(desired_in);
    prod = PW'(diff) * PW'(u_in);
  end

  anc_sat_round #(
    .IW   (PW),
    .OW   (DW),
    .FRAC (FRAC)
  ) u_sat_round (
    .din  (prod),
    .dout (wa_nxt),
    .ovf  (wa_ovf)
  );

  // Out-of-range channel tags match no bit, so they never touch the flags.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      set_vec[i] = accept && wa_ovf && (32'(in_ch) == i);
    end
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take      = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (fir_done) begin
          take      = 1'b1;
          state_nxt = HOLD;
        end else if (cnt == CW'(TMO)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_go          <= 1'b0;
      timeout         <= 1'b0;
      out_valid       <= 1'b0;
      weight_adjust   <= '0;
      feedforward_out <= '0;
      out_sample      <= '0;
      out_ch          <= '0;
      fir_ch          <= '0;
      sat_flags       <= '0;
      cnt             <= '0;
    end else begin
      fir_go    <= accept;
      timeout   <= tmo_hit;
      sat_flags <= (sat_flags & ~sat_clr) | set_vec;
      if (accept) begin
        fir_ch          <= in_ch;
        weight_adjust   <= wa_nxt;
        feedforward_out <= AW'(feedforward_in);
        cnt             <= '0;
      end else if (state == RUN && cnt != CW'(TMO)) begin
        cnt <= cnt + CW'(1);
      end
      if (take) begin
        out_valid  <= 1'b1;
        out_sample <= fir_out;
        out_ch     <= fir_ch;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lms_core_mc.md
LMS_CORE_MC -- requirements
Module: lms_core_mc

Interface
REQ-001 Parameter DW, default 16, signed sample/step-size width.
REQ-002 Parameter AW, default 32, signed FIR accumulator/output width.
REQ-003 Parameter FRAC, default 15, fractional bits of u_in.
REQ-004 Parameter NCH, default 4, channel count (>=1); CHW = max(1, clog2(NCH)).
REQ-005 Parameter TMO, default 255, max cycles waiting for fir_done (>=1).
REQ-006 Clocking is one clock, clk, with an asynchronous, active-low reset, rst_n.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 in_valid / in_ready  in / out  1 / 1  input handshake; transfer when both high on a rising edge.
REQ-010 in_ch  in  CHW  channel tag of the input sample.
REQ-011 error_in, desired_in, feedforward_in, u_in  in  DW each  signed operands.
REQ-012 fir_go  out  1  one-cycle FIR start pulse.
REQ-013 fir_ch  out  CHW  channel tag for the FIR; feedforward_out  out  AW  sign-extended feedforward.
REQ-014 fir_done  in  1  FIR completion pulse; fir_out  in  AW  signed FIR result.
REQ-015 out_valid / out_ready  out / in  1 / 1  output handshake; out_ch  out  CHW; out_sample  out  AW.
REQ-016 weight_adjust  out  DW  rounded, saturated step-scaled error; held until the next accepted input.
REQ-017 sat_flags  out  NCH  sticky per-channel saturation flags; sat_clr  in  NCH  per-bit clear.
REQ-018 timeout  out  1  one-cycle pulse on FIR timeout.

Function
REQ-019 The FSM states SHALL be IDLE, RUN, HOLD; in_ready SHALL equal (state==IDLE).
REQ-020 IDLE with in_valid: latch in_ch, compute weight_adjust, drive feedforward_out, pulse fir_go next cycle, clear the timeout counter, go to RUN.
REQ-021 The difference SHALL be computed in DW+1 bits: diff = error_in - desired_in, with no wrap.
REQ-022 The product SHALL be prod = diff * u_in, in 2*DW+1 bits.
REQ-023 weight_adjust = (prod + 2^(FRAC-1)) >>> FRAC, saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-024 On saturation, set sat_flags[in_ch].
REQ-025 If sat_clr[i] and a set of bit i coincide, the set SHALL win.
REQ-026 An in_ch >= NCH SHALL be accepted and processed, but SHALL NOT set any sat_flags bit.
REQ-027 RUN: the counter increments each cycle.
REQ-028 RUN, fir_done=1: latch out_sample=fir_out and out_ch, assert out_valid, go to HOLD.
REQ-029 RUN, counter==TMO with fir_done=0: pulse timeout, go to IDLE, no out_valid.
REQ-030 If fir_done and counter==TMO coincide, done SHALL win.
REQ-031 HOLD: out_valid, out_ch and out_sample SHALL remain stable until out_ready.
REQ-032 HOLD, out_ready=1: deassert out_valid and go to IDLE, which gives 1 cycle of turnaround before the next in_ready.
REQ-033 fir_done in IDLE or HOLD SHALL be ignored.
REQ-034 Latency from input accept to out_valid SHALL be 2 + (FIR cycles) clock cycles, minimum 2.
REQ-035 The arithmetic precision of weight_adjust SHALL be preserved across FRAC changes; no truncation other than that specified in REQ-023.

Reset
REQ-036 rst_n low SHALL asynchronously force state=IDLE, and outputs fir_go, out_valid, timeout, weight_adjust, feedforward_out, out_sample, out_ch, fir_ch, sat_flags and counter all to 0.
REQ-037 Reset mid-RUN or mid-HOLD SHALL drop any transaction in flight; a late fir_done after reset release SHALL be ignored.
REQ-038 in_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-039 Shared package anc_pkg SHALL hold the state encoding (IDLE=0, RUN=1, HOLD=2) and the round/saturate helper constants.
REQ-040 One combinational sub-module, anc_sat_round, SHALL implement round-half-up plus saturation, with an overflow flag.
REQ-041 The counter SHALL be clog2(TMO+1) bits wide.

Verification
REQ-042 error=1000, desired=200, u=16384 (0.5), FRAC=15 -> weight_adjust=400, sat_flags unchanged.
REQ-043 error=32767, desired=-32768, u=32767 -> weight_adjust=32767, sat_flags[in_ch]=1; then sat_clr -> 0.
REQ-044 fir_done 3 cycles after fir_go, fir_out=0x12345678, out_ready=0 for 4 cycles -> out_sample stable, out_valid held, in_ready=0.
REQ-045 No fir_done for TMO cycles -> one timeout pulse, no out_valid, in_ready=1 next cycle; fir_done and timeout together -> output taken.
REQ-046 rst_n pulsed low mid-RUN, then fir_done -> no out_valid, all outputs 0.
REQ-047 Back-to-back inputs on channels 0..NCH-1 -> out_ch matches each, in order.
